// File: rtl/timer_pkg.sv
// Shared types and constants for the down-counting timer.
package timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle between a controller and the down-counting timer.
interface down_counter_timer_if
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  // Controller side: issues commands, observes status.
  modport master (
    output load, load_data, start, pause, auto_reload,
    input  count, busy, tc, done
  );

  // Timer side: receives commands, reports status.
  modport slave (
    input  load, load_data, start, pause, auto_reload,
    output count, busy, tc, done
  );

endinterface

// File: rtl/down_counter_core.sv
// Count register with load / hold / decrement next-value selection.
module down_counter_core
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Next value: load wins, then hold, then a decrement that saturates at zero.
  always_comb begin
    count_next = count_reg;
    if (ld) begin
      count_next = ld_val;
    end else if (hold) begin
      count_next = count_reg;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count  = count_reg;
  assign is_one = (count_reg == WIDTH'(1));

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer: start/done handshake, pause, auto-reload.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  down_counter_timer_if.slave   bus
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;
  logic             busy_reg, done_reg;

  logic             core_ld;
  logic [WIDTH-1:0] core_ld_val;
  logic             core_dec;
  logic             core_hold;
  logic [WIDTH-1:0] count_w;
  logic             is_one_w;

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (core_ld),
    .ld_val  (core_ld_val),
    .dec     (core_dec),
    .hold    (core_hold),
    .count   (count_w),
    .is_one  (is_one_w)
  );

  // Next state and counter commands; priority is load > start > pause > decrement.
  always_comb begin
    state_next  = state_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    core_ld     = 1'b0;
    core_ld_val = reload_reg;
    core_dec    = 1'b0;
    core_hold   = 1'b1;
    if (bus.load) begin
      core_ld     = 1'b1;
      core_ld_val = bus.load_data;
      reload_next = bus.load_data;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          // A zero count would never reach a terminal count, so don't run.
          if (bus.start && (count_w != '0)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (bus.start) begin
            core_ld = 1'b1;
          end else if (bus.pause) begin
            core_hold = 1'b1;
          end else if (is_one_w) begin
            tc_next = 1'b1;
            if (bus.auto_reload) begin
              core_ld = 1'b1;
            end else begin
              core_dec   = 1'b1;
              core_hold  = 1'b0;
              state_next = DONE;
            end
          end else begin
            core_dec  = 1'b1;
            core_hold = 1'b0;
          end
        end
        DONE: begin
          if (bus.start && (reload_reg != '0)) begin
            core_ld    = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, reload and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
      busy_reg   <= (state_next == RUN);
      done_reg   <= (state_next == DONE);
    end
  end

  assign bus.count = count_w;
  assign bus.busy  = busy_reg;
  assign bus.tc    = tc_reg;
  assign bus.done  = done_reg;

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down-counting timer with start/done handshake, pause and optional auto-reload. It is the decrementing counterpart of the team's loadable up-counter. A controller preloads a period, starts the timer, and the timer counts to zero. It then raises a terminal-count pulse and either stops in DONE or reloads and keeps running. The block serves as the shared delay and period generator for control FSMs.

## Interface
- WIDTH, 4, counter and period width in bits (≥2)
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- load  in  1  capture load_data into count and reload register; aborts any run
- load_data  in  WIDTH  period value
- start  in  1  single-cycle request to begin or restart counting
- pause  in  1  level; holds count while in RUN
- auto_reload  in  1  level; sampled at terminal count
- count  out  WIDTH  current counter value
- busy  out  1  high while in RUN
- tc  out  1  registered one-cycle terminal-count pulse
- done  out  1  high while in DONE

## Operation
- States: IDLE, RUN, DONE.
- Reset values: count=0, reload register=0, state=IDLE, busy=0, tc=0, done=0.
- Priority is load > start > pause > decrement.
- load, in any state:
  - count and reload register take load_data.
  - State goes to IDLE.
  - tc is 0 that cycle.
- IDLE + start:
  - If count≠0, go to RUN; count unchanged.
  - If count==0, start is ignored and state stays IDLE.
- RUN, pause=1: count holds and state stays RUN.
- RUN, pause=0, count>1: count decrements by 1.
- RUN, pause=0, count==1 (terminal count):
  - auto_reload=1: count takes the reload register, tc=1, stay in RUN.
  - auto_reload=0: count goes to 0, tc=1, go to DONE.
- RUN + start (no load): restart; count takes the reload register and state stays RUN.
- DONE + start:
  - If reload≠0, count takes the reload register and state goes to RUN.
  - If reload==0, start is ignored.
- Arithmetic is unsigned WIDTH-bit.
- count never wraps below 0. The decrement from 0 is unreachable, because RUN is never entered with count==0.
- busy = (state==RUN). done = (state==DONE). Both are registered state decodes.

## Timing
- Start sampled at edge N: busy=1 after edge N. The first decrement is at edge N+1.
- Period P=load_data:
  - count shows 0 after edge N+P.
  - tc=1 for exactly the cycle following edge N+P.
  - done rises at that same edge.
- Auto-reload:
  - tc pulses every P cycles.
  - count sequence is P, P−1, …, 1, P, …
  - tc is coincident with count==P after the reload.
- Pause:
  - Each paused cycle extends the period by exactly one cycle.
  - pause asserted on the terminal cycle blocks tc until it is released.
- reset_n asserted mid-run forces all outputs to their reset values immediately (asynchronous). Deassertion is synchronized externally.
- Load during RUN takes effect at the next edge. No tc is generated and busy falls at that edge.

## Structure
- Package timer_pkg holds the `state_t` enum (IDLE, RUN, DONE) and a `DEFAULT_WIDTH` constant.
- Sub-module down_counter_core(WIDTH) holds the count register, the decrementer, and the load/reload/hold next-value mux.
  - Inputs: ld, ld_val, dec, hold.
  - Output: count, plus is_one (count==1).
- Top level contains the FSM, the reload register and the tc/done/busy registers.

## Test plan
- Reset mid-run: load 9, start, assert reset_n low after 3 cycles → count=0, busy=0, done=0, tc=0 immediately. The FSM stays IDLE after release.
- One-shot: load 5, start → count 5,4,3,2,1,0 on successive cycles, then:
  - tc high for one cycle with count==0;
  - done=1 and busy=0 from that cycle;
  - count holds 0.
- Auto-reload: load 3, auto_reload=1, start → count 3,2,1,3,2,1,3…; tc pulses every 3 cycles; done stays 0.
- Pause: load 4, start, hold pause for 2 cycles after first decrement → tc arrives 2 cycles later than unpaused (6 cycles after start instead of 4).
- Priority and boundaries:
  - load=7 and start in the same cycle during RUN → IDLE, count=7, no tc.
  - start with count==0 in IDLE → ignored.
  - start in DONE with reload 2 → RUN, count 2,1,0, tc.
  - WIDTH=4 load 15 → 15 cycles to tc.
